// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS core, with a retired-instruction counter.
// Define CTRL_ADDI_EN to add the addi path (DECODE -> ADDIEX -> ADDIWB).
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCEn,
    output logic             IorD,
    output logic             Memwrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUsrcA,
    output logic [1:0]       ALUsrcB,
    output logic [2:0]       ALUControl,
    output logic             PCsrc,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_ILLEGAL = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             funct_ok;
    logic [2:0]       funct_alu;

    // NOTE: every signal written in a combinational block gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = funct_ok ? S_ALUWB : S_ILLEGAL;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB: state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_ILLEGAL;
        endcase
    end

    // Retirement is the edge leaving a final state; ILLEGAL never retires.
    always_comb begin
        count_d = count_q;
        case (state_q)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB: count_d = count_q + CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        PCEn       = 1'b0;
        IorD       = 1'b0;
        Memwrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUsrcA    = 1'b0;
        ALUsrcB    = 2'b00;
        ALUControl = 3'b000;
        PCsrc      = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUsrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = 1'b1;
                PCEn       = 1'b1;
            end
            S_DECODE: begin
                ALUsrcB    = 2'b11;
                ALUControl = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUsrcA    = 1'b1;
                ALUsrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                Memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUsrcA    = 1'b1;
                ALUControl = funct_alu;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUsrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCsrc      = 1'b1;
                PCEn       = zero;
            end
            S_ILLEGAL: halted = 1'b1;
            default: halted = 1'b0;
        endcase
        // Reset must kill every strobe at once, even though the state decodes as FETCH.
        if (!rst) begin
            PCEn       = 1'b0;
            IorD       = 1'b0;
            Memwrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUsrcA    = 1'b0;
            ALUsrcB    = 2'b00;
            ALUControl = 3'b000;
            PCsrc      = 1'b0;
            halted     = 1'b0;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, corner
// sequences and randomized instructions against a per-instruction path model.
module tb_multicycle_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode, funct;
    logic             zero;
    logic             PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc, halted;
    logic [1:0]       ALUsrcB;
    logic [2:0]       ALUControl;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .PCEn(PCEn), .IorD(IorD), .Memwrite(Memwrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUsrcA(ALUsrcA),
        .ALUsrcB(ALUsrcB), .ALUControl(ALUControl), .PCsrc(PCsrc), .state(state),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef logic [3:0] st_t;
    localparam st_t FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5,
                    EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, ILLEGAL = 11;

    typedef struct packed {
        logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       pc_src;
        logic [3:0] st;
        logic       halted;
    } out_t;

    out_t act;
    assign act = {PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA,
                  ALUsrcB, ALUControl, PCsrc, state, halted};

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected,
                         input logic [31:0] mask);
        checks++;
        if (((actual ^ expected) & mask) != 0) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual & mask, expected & mask, $time);
        end
    endtask

    function automatic logic fn_legal(input logic [5:0] fn);
        foreach (legal_fn[i]) if (legal_fn[i] == fn) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Instruction class -> sequence of states it visits, starting at FETCH.
    function automatic int build_path(input logic [5:0] op, input logic [5:0] fn, output st_t p [6]);
        foreach (p[i]) p[i] = FETCH;
        p[1] = DECODE;
        case (op)
            6'b100011: begin p[2] = MEMADR; p[3] = MEMRD; p[4] = MEMWB; return 5; end
            6'b101011: begin p[2] = MEMADR; p[3] = MEMWR; return 4; end
            6'b000000: begin p[2] = EXECUTE; p[3] = fn_legal(fn) ? ALUWB : ILLEGAL; return 4; end
            6'b000100: begin p[2] = BRANCH; return 3; end
`ifdef CTRL_ADDI_EN
            6'b001000: begin p[2] = ADDIEX; p[3] = ADDIWB; return 4; end
`endif
            default:   begin p[2] = ILLEGAL; return 3; end
        endcase
    endfunction

    function automatic out_t exp_out(input st_t s, input logic [5:0] fn, input logic z);
        out_t o;
        o = '0;
        o.st = s;
        case (s)
            FETCH:          begin o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010; o.ir_write = 1; o.pc_en = 1; end
            DECODE:         begin o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; end
            MEMADR, ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
            MEMRD:          o.iord = 1;
            MEMWB:          begin o.mem_to_reg = 1; o.reg_write = 1; end
            MEMWR:          begin o.iord = 1; o.mem_write = 1; end
            EXECUTE:        begin o.alu_src_a = 1; o.alu_ctrl = alu_of(fn); end
            ALUWB:          begin o.reg_dst = 1; o.reg_write = 1; end
            ADDIWB:         o.reg_write = 1;
            BRANCH:         begin o.alu_src_a = 1; o.alu_ctrl = 3'b110; o.pc_src = 1; o.pc_en = z; end
            ILLEGAL:        o.halted = 1;
            default:        o = '0;
        endcase
        return o;
    endfunction

    task automatic check_cycle(input st_t s, input logic [5:0] fn);
        out_t mask;
        mask = '1;
        // ALU select for an undefined funct is unspecified.
        if (s == EXECUTE && !fn_legal(fn)) mask.alu_ctrl = '0;
        check($sformatf("outputs_st%0d", s), 32'(act), 32'(exp_out(s, fn, zero)), 32'(mask));
        check("instr_count", 32'(instr_count), 32'(model_cnt % (1 << CNT_W)), 32'hffff_ffff);
    endtask

    // Called at posedge+1; returns at posedge+2 with FETCH active and reset released.
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check("reset_outputs", 32'(act), 32'h0, 32'hffff_ffff);
        check("reset_count", 32'(instr_count), 32'h0, 32'hffff_ffff);
        model_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                             input int abort_at, output int lat);
        st_t p [6];
        int  len;
        len = build_path(op, fn, p);
        lat = 0;
        opcode = op;
        funct  = fn;
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                apply_reset();
                return;
            end
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            @(negedge clk);
            check_cycle(p[i], fn);
            if (i == 0 || state != FETCH) lat++;
            @(posedge clk); #1;
        end
        if (p[len-1] == ILLEGAL) begin
            for (int h = 0; h < 20; h++) begin
                zero = 1'($urandom_range(0, 1));
                @(negedge clk);
                check_cycle(ILLEGAL, fn);
                @(posedge clk); #1;
            end
            apply_reset();
        end else begin
            model_cnt++;
        end
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        int         zmode;
        int         lat;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        int abort;
        logic [5:0] op, fn;

        vecs.push_back('{"lw",        6'b100011, 6'b000000, -1, 5});
        vecs.push_back('{"sw",        6'b101011, 6'b000000, -1, 4});
        vecs.push_back('{"r_add",     6'b000000, 6'b100000, -1, 4});
        vecs.push_back('{"r_sub",     6'b000000, 6'b100010, -1, 4});
        vecs.push_back('{"r_and",     6'b000000, 6'b100100, -1, 4});
        vecs.push_back('{"r_or",      6'b000000, 6'b100101, -1, 4});
        vecs.push_back('{"r_slt",     6'b000000, 6'b101010, -1, 4});
        vecs.push_back('{"beq_taken", 6'b000100, 6'b000000,  1, 3});
        vecs.push_back('{"beq_not",   6'b000100, 6'b000000,  0, 3});
`ifdef CTRL_ADDI_EN
        vecs.push_back('{"addi",      6'b001000, 6'b000001, -1, 4});
`else
        vecs.push_back('{"addi_off",  6'b001000, 6'b000001, -1, 3});
`endif
        vecs.push_back('{"bad_funct", 6'b000000, 6'b000111, -1, 4});
        vecs.push_back('{"bad_op",    6'b111111, 6'b000000, -1, 3});

        rst = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        @(posedge clk); #1;
        apply_reset();

        // Reset pulled in EXECUTE aborts the instruction; FETCH resumes cleanly.
        run_instr(6'b000000, 6'b100010, -1, 2, lat);
        check("post_reset_fetch", {25'b0, PCEn, IRWrite, ALUsrcB, ALUControl}, {25'b0, 7'b1_1_01_010},
              32'hffff_ffff);

        foreach (vecs[v]) begin
            run_instr(vecs[v].op, vecs[v].fn, vecs[v].zmode, -1, lat);
            check($sformatf("latency_%s", vecs[v].name), 32'(lat), 32'(vecs[v].lat), 32'hffff_ffff);
        end

        // Counter wraps modulo 16 with CNT_W=4.
        apply_reset();
        for (int n = 0; n < 17; n++) begin
            run_instr(6'b101011, 6'b000000, -1, -1, lat);
            if (n == 14) check("wrap_15", 32'(instr_count), 32'd15, 32'hffff_ffff);
            if (n == 15) check("wrap_0",  32'(instr_count), 32'd0,  32'hffff_ffff);
            if (n == 16) check("wrap_1",  32'(instr_count), 32'd1,  32'hffff_ffff);
        end

        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, 9);
            fn = legal_fn[$urandom_range(0, 4)];
            case (k)
                0, 1:    op = 6'b100011;
                2:       op = 6'b101011;
                3, 4:    op = 6'b000000;
                5:       begin op = 6'b000000; fn = 6'($urandom); end
                6, 7:    op = 6'b000100;
                8:       op = 6'b001000;
                default: op = 6'($urandom);
            endcase
            abort = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 4) : -1;
            run_instr(op, fn, -1, abort, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle MIPS core. It sits directly beside the datapath: it consumes the datapath's `opcode`, `funct` and `zero`, and drives every datapath control strobe each cycle. It sequences fetch, decode, execute, memory and writeback for R-type, lw, sw and beq, with addi as a compile option. It also keeps a retired-instruction counter and flags illegal encodings by halting.

## Interface

Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `opcode`, in, 6: `Instr[31:26]` from the datapath.
- `funct`, in, 6: `Instr[5:0]` from the datapath.
- `zero`, in, 1: ALU result equals 0.
- `PCEn`, `IorD`, `Memwrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite`, `ALUsrcA`, out, 1 each: datapath strobes and mux selects.
- `ALUsrcB`, out, 2: 0 = B, 1 = constant 1 (word addressed), 2 or 3 = SignImm.
- `ALUControl`, out, 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCsrc`, out, 1: 0 = ALUResult, 1 = ALUOut.
- `state`, out, 4: current state, for debug.
- `halted`, out, 1: FSM is in ILLEGAL.
- `instr_count`, out, CNT_W: count of retired instructions.

## Operation

- The state register is 4 bits. States and their encodings are FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, ILLEGAL 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE goes to MEMADR for 100011 or 101011, EXECUTE for 000000, BRANCH for 000100, and ADDIEX for 001000 when enabled. Any other opcode goes to ILLEGAL.
  - MEMADR→MEMRD for lw, MEMADR→MEMWR for sw. MEMRD→MEMWB.
  - EXECUTE→ALUWB. EXECUTE→ILLEGAL if `funct` is not one of 100000, 100010, 100100, 100101, 101010.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH and ADDIWB all go to FETCH.
  - ILLEGAL holds until reset.
- Outputs are decoded combinationally from `state`. `PCEn` in BRANCH also depends on `zero`. Any output not listed for a state is 0.
  - FETCH: IorD=0, ALUsrcA=0, ALUsrcB=01, ALUControl=add, PCsrc=0, IRWrite=1, PCEn=1.
  - DECODE: ALUsrcA=0, ALUsrcB=11, ALUControl=add. This precomputes the branch target into ALUOut.
  - MEMADR and ADDIEX: ALUsrcA=1, ALUsrcB=10, ALUControl=add.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, Memwrite=1.
  - EXECUTE: ALUsrcA=1, ALUsrcB=00, ALUControl from `funct`: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUsrcA=1, ALUsrcB=00, ALUControl=sub, PCsrc=1, PCEn=`zero`.
  - ILLEGAL: all strobes 0, `halted`=1.
- Retired-instruction counter:
  - `instr_count` increments by 1 on every edge that leaves MEMWB, MEMWR, ALUWB, BRANCH or ADDIWB. A not-taken beq counts as retired.
  - It wraps modulo 2^CNT_W with no saturation.
  - It never increments in ILLEGAL.

## Timing

- Reset value while `rst`=0: state=FETCH(0), `instr_count`=0, `halted`=0.
- While `rst`=0, all outputs are forced to 0, including `PCEn`, `IRWrite`, `RegWrite` and `Memwrite`.
- The first cycle after `rst` rises is FETCH with its normal decode.
- Reset asserted mid-instruction aborts it immediately and asynchronously. No strobe survives, and the aborted instruction is not counted.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3.
- `opcode` and `funct` are sampled only in DECODE, EXECUTE and MEMADR. The datapath holds `Instr` stable after FETCH, because IRWrite is high only in FETCH.
- `zero` is used only in BRANCH, in the same cycle; the path is combinational.

## Configuration

- `CTRL_ADDI_EN` defined: opcode 001000 follows DECODE→ADDIEX→ADDIWB→FETCH and retires normally.
- `CTRL_ADDI_EN` undefined: opcode 001000 goes from DECODE to ILLEGAL. States 9 and 10 are unreachable and their encodings are never output.

## Test plan

- Reset: pull `rst` low during EXECUTE. Required: state=0, all outputs 0, `instr_count`=0. After release, cycle 1 is FETCH with PCEn=1, IRWrite=1, ALUsrcB=01, ALUControl=010.
- lw (opcode 100011): `state` follows 0,1,2,3,4,0. MEMRD has IorD=1. MEMWB has RegWrite=1, MemtoReg=1, RegDst=0. `instr_count` goes 0→1 on return to FETCH.
- R-type: funct 100010 gives ALUControl=110 in EXECUTE, then ALUWB with RegDst=1 and RegWrite=1. Repeat with funct 101010 → ALUControl=111. Funct 000111 → ILLEGAL with `halted`=1.
- beq (000100): with zero=1, BRANCH has PCEn=1 and PCsrc=1. With zero=0, PCEn=0. Each case returns to FETCH after 3 cycles total and `instr_count` increments.
- addi (001000): with `CTRL_ADDI_EN`, sequence is 0,1,9,10,0 with ADDIWB RegWrite=1, RegDst=0, MemtoReg=0. Without it, 0,1,11, then held in 11 for 20 cycles with `instr_count` frozen.
- Wrap: set CNT_W=4 and run 17 sw instructions. Required: `instr_count` reads 15, then 0, then 1, and every MEMWR asserts Memwrite=1 and IorD=1.
